// File: rtl/port_resp_arb_if.sv
// Port-request handshake bundle between the requesters of one output port and its responder.
// The slave side is the responder (port_resp_arb); the master side drives the requests.
interface port_resp_arb_if #(
    parameter int unsigned REQNUM = 16
) ();
    localparam int unsigned IDW = (REQNUM > 1) ? $clog2(REQNUM) : 1;

    logic [REQNUM-1:0] i_req;
    logic              i_port_en;
    logic              i_r_finish;
    logic              o_port_ready;
    logic [REQNUM-1:0] o_resp;
    logic [REQNUM-1:0] o_nresp;
    logic [IDW-1:0]    o_grant_id;
    logic              o_grant_vld;
    logic              o_timeout;

    modport slave (
        input  i_req,
        input  i_port_en,
        input  i_r_finish,
        output o_port_ready,
        output o_resp,
        output o_nresp,
        output o_grant_id,
        output o_grant_vld,
        output o_timeout
    );

    modport master (
        output i_req,
        output i_port_en,
        output i_r_finish,
        input  o_port_ready,
        input  o_resp,
        input  o_nresp,
        input  o_grant_id,
        input  o_grant_vld,
        input  o_timeout
    );
endinterface

// File: rtl/port_resp_arb.sv
// Output-port responder: round-robin grants one requester per transfer, rejects the rest,
// and holds the port until the winner reports read completion or the busy watchdog expires.
module port_resp_arb #(
    parameter int unsigned REQNUM      = 16,
    parameter int unsigned TIMEOUT_MAX = 1024
) (
    input  logic           i_clk,
    input  logic           i_rst,
    port_resp_arb_if.slave bus
);
    localparam int unsigned IDW  = (REQNUM > 1) ? $clog2(REQNUM) : 1;
    localparam int unsigned IW   = IDW + 1;
    localparam int unsigned CntW = (TIMEOUT_MAX > 1) ? $clog2(TIMEOUT_MAX) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_MAX - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [REQNUM-1:0] nack_q, nack_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              port_ready_q, port_ready_d;
    logic [REQNUM-1:0] resp_q, resp_d;
    logic [REQNUM-1:0] nresp_q, nresp_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              grant_vld_q, grant_vld_d;
    logic              timeout_q, timeout_d;

    logic [REQNUM-1:0] elig;
    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [REQNUM-1:0] win_oh;
    logic              timeout_hit;

    assign elig        = bus.i_req & ~nack_q;
    assign timeout_hit = (TIMEOUT_MAX != 0) && (cnt_q == CntLast);

    // Scan from ptr upward, wrapping modulo REQNUM (REQNUM need not be a power of two).
    always_comb begin
        logic [IW-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < REQNUM; i++) begin
            cand = {1'b0, ptr_q} + IW'(i);
            if (cand >= IW'(REQNUM)) begin
                cand = cand - IW'(REQNUM);
            end
            if (!win_found && elig[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_port_en && win_found) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (bus.i_r_finish || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        resp_d      = '0;
        nresp_d     = '0;
        grant_id_d  = grant_id_q;
        grant_vld_d = grant_vld_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.i_port_en) begin
                    nresp_d = elig;
                end else if (win_found) begin
                    resp_d      = win_oh;
                    nresp_d     = elig & ~win_oh;
                    grant_id_d  = win_idx;
                    grant_vld_d = 1'b1;
                    cnt_d       = '0;
                    ptr_d       = (win_idx == IDW'(REQNUM - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            StBusy: begin
                // A finishing cycle leaves new requesters unrejected so IDLE can arbitrate them.
                if (bus.i_r_finish) begin
                    grant_vld_d = 1'b0;
                end else begin
                    nresp_d             = elig;
                    nresp_d[grant_id_q] = 1'b0;
                    if (timeout_hit) begin
                        timeout_d   = 1'b1;
                        grant_vld_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        nack_d       = (nack_q & bus.i_req) | nresp_d;
        port_ready_d = (state_d == StIdle) && bus.i_port_en;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q        <= '0;
            nack_q       <= '0;
            cnt_q        <= '0;
            port_ready_q <= 1'b0;
            resp_q       <= '0;
            nresp_q      <= '0;
            grant_id_q   <= '0;
            grant_vld_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            nack_q       <= nack_d;
            cnt_q        <= cnt_d;
            port_ready_q <= port_ready_d;
            resp_q       <= resp_d;
            nresp_q      <= nresp_d;
            grant_id_q   <= grant_id_d;
            grant_vld_q  <= grant_vld_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.o_port_ready = port_ready_q;
    assign bus.o_resp       = resp_q;
    assign bus.o_nresp      = nresp_q;
    assign bus.o_grant_id   = grant_id_q;
    assign bus.o_grant_vld  = grant_vld_q;
    assign bus.o_timeout    = timeout_q;

endmodule

// File: tb/tb_port_resp_arb.sv
// Directed bench for port_resp_arb (REQNUM=16, TIMEOUT_MAX=8) with hand-computed expectations.
module tb_port_resp_arb;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    port_resp_arb_if #(.REQNUM(16)) bus ();

    port_resp_arb #(
        .REQNUM     (16),
        .TIMEOUT_MAX(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic pr, input logic [15:0] resp,
                              input logic [15:0] nresp, input logic vld, input logic to);
        chk({tag, ".port_ready"}, 32'(bus.o_port_ready), 32'(pr));
        chk({tag, ".resp"},       32'(bus.o_resp),       32'(resp));
        chk({tag, ".nresp"},      32'(bus.o_nresp),      32'(nresp));
        chk({tag, ".grant_vld"},  32'(bus.o_grant_vld),  32'(vld));
        chk({tag, ".timeout"},    32'(bus.o_timeout),    32'(to));
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_req      = '0;
        bus.i_port_en  = 1'b0;
        bus.i_r_finish = 1'b0;
        #12;
        expect_out("reset", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("reset.grant_id", 32'(bus.o_grant_id), 32'd0);
        rst           = 1'b0;
        bus.i_port_en = 1'b1;
        tick();
        expect_out("rel", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Single request, ptr 0 -> winner 2
        bus.i_req = 16'h0004;
        tick();
        expect_out("single", 1'b0, 16'h0004, 16'h0, 1'b1, 1'b0);
        chk("single.grant_id", 32'(bus.o_grant_id), 32'd2);
        bus.i_req = '0;
        tick();
        expect_out("single.hold", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        bus.i_r_finish = 1'b1;
        tick();
        bus.i_r_finish = 1'b0;
        expect_out("single.fin", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Round robin from ptr 3, then wrap to 0
        bus.i_req = 16'h0009;
        tick();
        expect_out("rr1", 1'b0, 16'h0008, 16'h0001, 1'b1, 1'b0);
        chk("rr1.grant_id", 32'(bus.o_grant_id), 32'd3);
        bus.i_req = '0;
        tick();
        bus.i_r_finish = 1'b1;
        tick();
        bus.i_r_finish = 1'b0;
        expect_out("rr1.fin", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.i_req = 16'h0009;
        tick();
        expect_out("rr2", 1'b0, 16'h0001, 16'h0008, 1'b1, 1'b0);
        chk("rr2.grant_id", 32'(bus.o_grant_id), 32'd0);
        bus.i_req = '0;
        tick();

        // New request alongside finish: no reject, granted from IDLE one cycle later
        bus.i_req      = 16'h0010;
        bus.i_r_finish = 1'b1;
        tick();
        bus.i_r_finish = 1'b0;
        expect_out("finreq", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        expect_out("finreq.grant", 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0);
        chk("finreq.grant_id", 32'(bus.o_grant_id), 32'd4);
        bus.i_req = '0;

        // Busy reject: one pulse per assertion even when held
        bus.i_req = 16'h0020;
        tick();
        expect_out("busyrej.1", 1'b0, 16'h0, 16'h0020, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("busyrej.held", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        bus.i_req = '0;
        tick();
        expect_out("busyrej.drop", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        bus.i_req = 16'h0020;
        tick();
        expect_out("busyrej.2", 1'b0, 16'h0, 16'h0020, 1'b1, 1'b0);
        bus.i_req = 16'h0010;
        tick();
        expect_out("busy.winner", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        bus.i_req      = '0;
        bus.i_r_finish = 1'b1;
        tick();
        bus.i_r_finish = 1'b0;
        expect_out("busyrej.fin", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Port disabled: reject once, stay idle
        bus.i_port_en = 1'b0;
        bus.i_req     = 16'h8000;
        tick();
        expect_out("dis", 1'b0, 16'h0, 16'h8000, 1'b0, 1'b0);
        tick();
        expect_out("dis.held", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.i_req     = '0;
        bus.i_port_en = 1'b1;
        tick();
        expect_out("dis.en", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Finish in IDLE is ignored
        bus.i_r_finish = 1'b1;
        tick();
        bus.i_r_finish = 1'b0;
        expect_out("idlefin", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Watchdog: ptr 5, request 6 -> timeout on the 8th edge after the grant
        bus.i_req = 16'h0040;
        tick();
        expect_out("wd", 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0);
        chk("wd.grant_id", 32'(bus.o_grant_id), 32'd6);
        bus.i_req = '0;
        for (int i = 1; i < 8; i++) begin
            tick();
            expect_out("wd.wait", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        end
        tick();
        expect_out("wd.expire", 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
        tick();
        expect_out("wd.after", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Finish coinciding with expiry wins
        bus.i_req = 16'h0080;
        tick();
        expect_out("wdfin", 1'b0, 16'h0080, 16'h0, 1'b1, 1'b0);
        chk("wdfin.grant_id", 32'(bus.o_grant_id), 32'd7);
        bus.i_req = '0;
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        expect_out("wdfin.wait", 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        bus.i_r_finish = 1'b1;
        tick();
        bus.i_r_finish = 1'b0;
        expect_out("wdfin.edge", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        expect_out("wdfin.after", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);

        // Reset mid-busy: outputs clear asynchronously, ptr returns to 0
        bus.i_req = 16'h0100;
        tick();
        expect_out("rstbusy", 1'b0, 16'h0100, 16'h0, 1'b1, 1'b0);
        bus.i_req = '0;
        #2;
        rst = 1'b1;
        #1;
        expect_out("rstbusy.async", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("rstbusy.grant_id", 32'(bus.o_grant_id), 32'd0);
        tick();
        expect_out("rstbusy.held", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        expect_out("rstbusy.rel", 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        bus.i_req = 16'h0003;
        tick();
        expect_out("rstbusy.grant", 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b0);
        chk("rstbusy.grant_id2", 32'(bus.o_grant_id), 32'd0);
        bus.i_req = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
